// File: rtl/trigger_pkg.sv
// Shared definitions for the multi-stage trigger sequencer: FSM states,
// default parameter values and the per-stage slice index helpers.
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 33;
    localparam int DEF_CNT_W  = 17;
    localparam int DEF_STAGES = 4;

    // Low bit of stage k's field inside a flattened per-stage bus
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

    // Width of a stage index; a single-stage build still needs one bit
    function automatic int stage_w(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/trigger_match.sv
// One stage's masked compare: hit when every cared-for bit of data equals value.
module trigger_match #(
    parameter int DATA_W = trigger_pkg::DEF_DATA_W
) (
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] care,
    input  logic [DATA_W-1:0] data,
    output logic              hit
);

    assign hit = ~|((data ^ value) & care);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger: each stage waits for a masked data match at an exact
// cycle offset (or at-or-after it) from stage entry; the last stage fires trig.
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STAGES = DEF_STAGES
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [DATA_W-1:0]             data,
    input  logic [STAGES*DATA_W-1:0]      cfg_value,
    input  logic [STAGES*DATA_W-1:0]      cfg_care,
    input  logic [STAGES*CNT_W-1:0]       cfg_offset,
    input  logic [STAGES-1:0]             cfg_window,
    input  logic [$clog2(STAGES+1)-1:0]   cfg_stages,
    output logic                          trig,
    output logic                          triggered,
    output logic                          armed,
    output logic [stage_w(STAGES)-1:0]    stage
);

    localparam int STG_W = stage_w(STAGES);
    localparam int NS_W  = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [STG_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               trig_q, trig_d;
    logic               triggered_q, triggered_d;

    logic [STAGES-1:0]  hit_vec;
    logic [CNT_W-1:0]   offset_a [STAGES];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            trigger_match #(
                .DATA_W (DATA_W)
            ) u_match (
                .value (cfg_value[slice_lo(k, DATA_W) +: DATA_W]),
                .care  (cfg_care[slice_lo(k, DATA_W) +: DATA_W]),
                .data  (data),
                .hit   (hit_vec[k])
            );
            assign offset_a[k] = cfg_offset[slice_lo(k, CNT_W) +: CNT_W];
        end
    endgenerate

    logic               sel_hit;
    logic               sel_win;
    logic [CNT_W-1:0]   sel_off;
    logic               time_ok;
    logic               late;

    always_comb begin
        sel_hit = hit_vec[stage_q];
        sel_off = offset_a[stage_q];
        sel_win = cfg_window[stage_q];
        time_ok = sel_win ? (count_q >= sel_off) : (count_q == sel_off);
        // Only exact-mode stages can miss their slot; window stages wait forever
        late    = !sel_win && (count_q > sel_off);
    end

    logic [NS_W-1:0] nst;

    always_comb begin
        if (cfg_stages == '0) begin
            nst = NS_W'(1);
        end else if (cfg_stages > NS_W'(STAGES)) begin
            nst = NS_W'(STAGES);
        end else begin
            nst = cfg_stages;
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        last_d      = last_q;
        count_d     = count_q;
        trig_d      = 1'b0;
        triggered_d = triggered_q;

        if (!start) begin
            state_d     = IDLE;
            stage_d     = '0;
            count_d     = '0;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    last_d  = STG_W'(nst - NS_W'(1));
                    stage_d = '0;
                    count_d = '0;
                end
                ARMED: begin
                    if (sel_hit && time_ok) begin
                        if (stage_q == last_q) begin
                            state_d     = FIRED;
                            trig_d      = 1'b1;
                            triggered_d = 1'b1;
                        end else begin
                            stage_d = stage_q + 1'b1;
                            count_d = '0;
                        end
                    end else if (late) begin
                        stage_d = '0;
                        count_d = '0;
                    end else if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
                FIRED: begin
                    // Hold until start drops
                end
                default: begin
                    state_d = IDLE;
                    stage_d = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            last_q      <= '0;
            count_q     <= '0;
            trig_q      <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            last_q      <= last_d;
            count_q     <= count_d;
            trig_q      <= trig_d;
            triggered_q <= triggered_d;
        end
    end

    assign trig      = trig_q;
    assign triggered = triggered_q;
    assign armed     = (state_q == ARMED);
    assign stage     = stage_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
`timescale 1ns/1ps
module tb_trigger_sequencer;

    localparam int DATA_W = 33;
    localparam int CNT_W  = 10;
    localparam int STAGES = 4;
    localparam int STG_W  = 2;
    localparam int NS_W   = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     start = 1'b0;
    logic [DATA_W-1:0]        data = '0;
    logic [STAGES*DATA_W-1:0] cfg_value = '0;
    logic [STAGES*DATA_W-1:0] cfg_care = '0;
    logic [STAGES*CNT_W-1:0]  cfg_offset = '0;
    logic [STAGES-1:0]        cfg_window = '0;
    logic [NS_W-1:0]          cfg_stages = '0;
    logic                     trig;
    logic                     triggered;
    logic                     armed;
    logic [STG_W-1:0]         stage;

    trigger_sequencer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .STAGES (STAGES)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .data       (data),
        .cfg_value  (cfg_value),
        .cfg_care   (cfg_care),
        .cfg_offset (cfg_offset),
        .cfg_window (cfg_window),
        .cfg_stages (cfg_stages),
        .trig       (trig),
        .triggered  (triggered),
        .armed      (armed),
        .stage      (stage)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit [DATA_W-1:0] val  [STAGES];
    bit [DATA_W-1:0] care [STAGES];
    int              off  [STAGES];
    bit              win  [STAGES];
    int              nst;

    // Reference model state
    bit m_armed, m_fired, m_trig, m_trd;
    int m_stage, m_count, m_last;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_armed = 0; m_fired = 0; m_trig = 0; m_trd = 0;
        m_stage = 0; m_count = 0;
    endfunction

    function automatic void model_step();
        bit hit, ontime;
        m_trig = 0;
        if (!start) begin
            model_reset();
        end else if (!m_armed && !m_fired) begin
            m_armed = 1; m_stage = 0; m_count = 0;
            m_last  = (nst == 0) ? 0 : ((nst > STAGES) ? STAGES - 1 : nst - 1);
        end else if (m_armed) begin
            hit    = ((data ^ val[m_stage]) & care[m_stage]) == '0;
            ontime = win[m_stage] ? (m_count >= off[m_stage]) : (m_count == off[m_stage]);
            if (hit && ontime) begin
                if (m_stage == m_last) begin
                    m_armed = 0; m_fired = 1; m_trig = 1; m_trd = 1;
                end else begin
                    m_stage = m_stage + 1; m_count = 0;
                end
            end else if (!win[m_stage] && m_count > off[m_stage]) begin
                m_stage = 0; m_count = 0;
            end else begin
                m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
            end
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_trig", int'(trig), int'(m_trig));
            check("cyc_triggered", int'(triggered), int'(m_trd));
            check("cyc_armed", int'(armed), int'(m_armed));
            check("cyc_stage", int'(stage), m_stage);
        end
    end

    function automatic void clear_cfg();
        for (int k = 0; k < STAGES; k++) begin
            val[k] = '0; care[k] = '0; off[k] = 0; win[k] = 0;
        end
        nst = 1;
    endfunction

    task automatic apply_cfg();
        for (int k = 0; k < STAGES; k++) begin
            cfg_value[k*DATA_W +: DATA_W] = val[k];
            cfg_care[k*DATA_W +: DATA_W]  = care[k];
            cfg_offset[k*CNT_W +: CNT_W]  = CNT_W'(off[k]);
            cfg_window[k]                 = win[k];
        end
        cfg_stages = NS_W'(nst);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic bit [DATA_W-1:0] rnd_word();
        bit [63:0] w;
        w = {$urandom(), $urandom()};
        return w[DATA_W-1:0];
    endfunction

    task automatic three_stage_cfg();
        clear_cfg();
        val[0] = 'hA; care[0] = '1; off[0] = 0; win[0] = 0;
        val[1] = 'hB; care[1] = '1; off[1] = 5; win[1] = 1;
        care[2] = '0; off[2] = 2; win[2] = 0;
        nst = 3;
        apply_cfg();
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        clear_cfg();
        apply_cfg();
        #3;
        chk_en = 1'b1;
        check("rst_trig", int'(trig), 0);
        check("rst_triggered", int'(triggered), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_stage", int'(stage), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single stage, exact offset 1, match on the second armed cycle
        val[0] = 4; care[0] = '1; off[0] = 1; win[0] = 0; nst = 1;
        apply_cfg();
        start = 1; data = 0;
        tick();
        check("s35_armed", int'(armed), 1);
        check("s35_stage", int'(stage), 0);
        tick();
        data = 4;
        tick();
        check("s35_trig", int'(trig), 1);
        check("s35_triggered", int'(triggered), 1);
        check("s35_fired_not_armed", int'(armed), 0);
        data = 0;
        tick();
        check("s35_trig_one_cycle", int'(trig), 0);
        check("s35_triggered_hold", int'(triggered), 1);
        start = 0;
        tick();
        check("s35_disarm_clears", int'(triggered), 0);

        // Late sample misses the exact slot and restarts the sequence
        start = 1;
        tick();
        data = 0;
        tick(2);
        data = 4;
        tick();
        check("s36_late_no_trig", int'(trig), 0);
        check("s36_still_armed", int'(armed), 1);
        data = 0;
        tick();
        data = 4;
        tick();
        check("s36_retry_trig", int'(trig), 1);
        start = 0; data = 0;
        tick();

        // Three stages: exact, window, don't-care exact
        three_stage_cfg();
        start = 1;
        tick();
        data = 'hA;
        tick();
        check("s37_stage1", int'(stage), 1);
        data = 'hB;
        lat = 0;
        while (!trig && lat < 40) begin
            tick();
            lat++;
            if (lat == 5) check("s37_stage1_hold", int'(stage), 1);
            if (lat == 6) check("s37_stage2", int'(stage), 2);
        end
        check("s37_latency", lat, 9);
        start = 0; data = 0;
        tick();

        // Window stage at maximum offset: only a saturated count can match
        clear_cfg();
        val[0] = 7; care[0] = '1; off[0] = CMAX; win[0] = 1; nst = 1;
        apply_cfg();
        start = 1;
        tick();
        data = 0;
        tick(500);
        data = 7;
        tick();
        check("s38_early_blocked", int'(trig), 0);
        data = 0;
        tick(1000);
        check("s38_waiting", int'(armed), 1);
        data = 7;
        tick();
        check("s38_saturated_fire", int'(trig), 1);
        start = 0; data = 0;
        tick();

        // Zero care, offset 0: matches on the first cycle; start drop cancels it
        clear_cfg();
        apply_cfg();
        start = 1;
        tick();
        start = 0;
        tick();
        check("s39_no_trig", int'(trig), 0);
        check("s39_idle", int'(armed), 0);
        check("s39_triggered", int'(triggered), 0);
        start = 1;
        tick();
        check("s39_rearm", int'(armed), 1);
        check("s39_stage0", int'(stage), 0);
        tick();
        check("s28_first_cycle_match", int'(trig), 1);
        start = 0;
        tick();

        // Oversized stage count clamps to four stages
        nst = 7;
        apply_cfg();
        start = 1;
        tick();
        tick(3);
        check("clamp_stage3", int'(stage), 3);
        check("clamp_not_yet", int'(trig), 0);
        tick();
        check("clamp_trig", int'(trig), 1);
        start = 0;
        tick();

        // Asynchronous reset in the middle of stage 2
        three_stage_cfg();
        start = 1;
        tick();
        data = 'hA;
        tick();
        data = 'hB;
        tick(6);
        check("s40_in_stage2", int'(stage), 2);
        #1 reset_n = 0;
        #1;
        check("s40_rst_armed", int'(armed), 0);
        check("s40_rst_stage", int'(stage), 0);
        check("s40_rst_trig", int'(trig), 0);
        check("s40_rst_triggered", int'(triggered), 0);
        #1 reset_n = 1;
        data = 'hA;
        tick();
        check("s40_rearm", int'(armed), 1);
        check("s40_restart_stage0", int'(stage), 0);
        tick();
        check("s40_stage1", int'(stage), 1);
        start = 0; data = 0;
        tick();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!start) begin
                if ($urandom_range(0, 1) == 0) begin
                    for (int k = 0; k < STAGES; k++) begin
                        val[k]  = rnd_word();
                        care[k] = ($urandom_range(0, 3) == 0) ? '0 : rnd_word();
                        off[k]  = $urandom_range(0, 6);
                        win[k]  = $urandom_range(0, 1);
                    end
                    nst = $urandom_range(0, 7);
                    apply_cfg();
                end
                start = ($urandom_range(0, 2) != 0);
            end else if (m_fired) begin
                start = ($urandom_range(0, 3) != 0);
            end else begin
                start = ($urandom_range(0, 59) != 0);
            end
            if ($urandom_range(0, 1) == 0)
                data = val[m_stage] ^ (rnd_word() & ~care[m_stage]);
            else
                data = rnd_word();
            tick();
        end

        start = 0;
        tick(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
